// File: rtl/register_bank.sv
// Multi-entry register bank: one write port and two registered read ports.
// Includes same-cycle write-to-read bypass and a synchronous clear of the whole bank.
module register_bank #(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      DEPTH       = 8,
  parameter int unsigned      ADDR_W      = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             wr_ok;
  logic             rd_ok_a;
  logic             rd_ok_b;
  logic [WIDTH-1:0] rd_next_a;
  logic [WIDTH-1:0] rd_next_b;

  // Addresses can exceed DEPTH when DEPTH is not a power of two.
  assign wr_ok   = wr_en && (32'(wr_addr) < DEPTH);
  assign rd_ok_a = 32'(rd_addr_a) < DEPTH;
  assign rd_ok_b = 32'(rd_addr_b) < DEPTH;

  // Port A: out-of-range reads return zero; a matching write bypasses storage.
  always_comb begin
    rd_next_a = mem[rd_addr_a];
    if (!rd_ok_a) begin
      rd_next_a = '0;
    end else if (wr_en && (wr_addr == rd_addr_a)) begin
      rd_next_a = wr_data;
    end
  end

  // Port B: same selection as port A.
  always_comb begin
    rd_next_b = mem[rd_addr_b];
    if (!rd_ok_b) begin
      rd_next_b = '0;
    end else if (wr_en && (wr_addr == rd_addr_b)) begin
      rd_next_b = wr_data;
    end
  end

  // Storage and read registers; clear outranks any write in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= RESET_VALUE;
      end
      rd_data_a <= RESET_VALUE;
      rd_data_b <= RESET_VALUE;
    end else if (clear) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= RESET_VALUE;
      end
      rd_data_a <= RESET_VALUE;
      rd_data_b <= RESET_VALUE;
    end else begin
      if (wr_ok) begin
        mem[wr_addr] <= wr_data;
      end
      rd_data_a <= rd_next_a;
      rd_data_b <= rd_next_b;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: three instances cover the default 8x8 bank,
// a non-power-of-two depth with a non-zero reset value, and a 16-bit word.
module tb_register_bank;

  logic clock;
  logic reset;

  // 8x8, RESET_VALUE 0
  logic       c8_clear, c8_wr_en;
  logic [2:0] c8_wr_addr, c8_rd_addr_a, c8_rd_addr_b;
  logic [7:0] c8_wr_data, c8_rd_data_a, c8_rd_data_b;

  // depth 6, RESET_VALUE 8'h5A
  logic       d6_clear, d6_wr_en;
  logic [2:0] d6_wr_addr, d6_rd_addr_a, d6_rd_addr_b;
  logic [7:0] d6_wr_data, d6_rd_data_a, d6_rd_data_b;

  // 16-bit words
  logic        w16_clear, w16_wr_en;
  logic [2:0]  w16_wr_addr, w16_rd_addr_a, w16_rd_addr_b;
  logic [15:0] w16_wr_data, w16_rd_data_a, w16_rd_data_b;

  int checks = 0;
  int errors = 0;

  register_bank #(.WIDTH(8), .DEPTH(8), .RESET_VALUE(8'h00)) u_c8 (
    .clock(clock), .reset(reset), .clear(c8_clear), .wr_en(c8_wr_en),
    .wr_addr(c8_wr_addr), .wr_data(c8_wr_data),
    .rd_addr_a(c8_rd_addr_a), .rd_data_a(c8_rd_data_a),
    .rd_addr_b(c8_rd_addr_b), .rd_data_b(c8_rd_data_b)
  );

  register_bank #(.WIDTH(8), .DEPTH(6), .RESET_VALUE(8'h5A)) u_d6 (
    .clock(clock), .reset(reset), .clear(d6_clear), .wr_en(d6_wr_en),
    .wr_addr(d6_wr_addr), .wr_data(d6_wr_data),
    .rd_addr_a(d6_rd_addr_a), .rd_data_a(d6_rd_data_a),
    .rd_addr_b(d6_rd_addr_b), .rd_data_b(d6_rd_data_b)
  );

  register_bank #(.WIDTH(16), .DEPTH(8), .RESET_VALUE(16'h0000)) u_w16 (
    .clock(clock), .reset(reset), .clear(w16_clear), .wr_en(w16_wr_en),
    .wr_addr(w16_wr_addr), .wr_data(w16_wr_data),
    .rd_addr_a(w16_rd_addr_a), .rd_data_a(w16_rd_data_a),
    .rd_addr_b(w16_rd_addr_b), .rd_data_b(w16_rd_data_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    c8_clear = 0;  c8_wr_en = 0;  c8_wr_addr = 0;  c8_wr_data = 0;  c8_rd_addr_a = 0;  c8_rd_addr_b = 0;
    d6_clear = 0;  d6_wr_en = 0;  d6_wr_addr = 0;  d6_wr_data = 0;  d6_rd_addr_a = 0;  d6_rd_addr_b = 0;
    w16_clear = 0; w16_wr_en = 0; w16_wr_addr = 0; w16_wr_data = 0; w16_rd_addr_a = 0; w16_rd_addr_b = 0;

    repeat (2) step();
    check("c8 reset a", c8_rd_data_a, 16'h0000);
    check("c8 reset b", c8_rd_data_b, 16'h0000);
    check("d6 reset a", d6_rd_data_a, 16'h005A);
    check("d6 reset b", d6_rd_data_b, 16'h005A);
    check("w16 reset a", w16_rd_data_a, 16'h0000);
    reset = 1'b0;
    step();

    // Write AA to entry 3, then reset mid-cycle
    c8_wr_en = 1; c8_wr_addr = 3; c8_wr_data = 8'hAA; c8_rd_addr_a = 3; c8_rd_addr_b = 3;
    step();
    check("c8 pre-reset bypass a", c8_rd_data_a, 16'h00AA);
    c8_wr_en = 0;
    #2 reset = 1'b1;
    #1;
    check("c8 async reset a", c8_rd_data_a, 16'h0000);
    check("c8 async reset b", c8_rd_data_b, 16'h0000);
    #1 reset = 1'b0;
    step();
    check("c8 entry3 after reset a", c8_rd_data_a, 16'h0000);
    check("c8 entry3 after reset b", c8_rd_data_b, 16'h0000);

    // Write/read with hold
    c8_wr_en = 1; c8_wr_addr = 1; c8_wr_data = 8'hAA; c8_rd_addr_a = 0; c8_rd_addr_b = 0;
    step();
    c8_wr_addr = 6; c8_wr_data = 8'h55;
    step();
    c8_wr_en = 0; c8_rd_addr_a = 1; c8_rd_addr_b = 6;
    step();
    check("c8 read e1 a", c8_rd_data_a, 16'h00AA);
    check("c8 read e6 b", c8_rd_data_b, 16'h0055);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("c8 hold%0d a", k), c8_rd_data_a, 16'h00AA);
      check($sformatf("c8 hold%0d b", k), c8_rd_data_b, 16'h0055);
    end

    // Bypass: both ports see the new value in the write cycle
    c8_wr_en = 1; c8_wr_addr = 2; c8_wr_data = 8'h11;
    step();
    c8_wr_data = 8'h22; c8_rd_addr_a = 2; c8_rd_addr_b = 2;
    step();
    check("c8 bypass a", c8_rd_data_a, 16'h0022);
    check("c8 bypass b", c8_rd_data_b, 16'h0022);
    c8_wr_en = 0;
    step();
    check("c8 e2 stored a", c8_rd_data_a, 16'h0022);

    // Clear outranks a simultaneous write
    c8_wr_en = 1;
    for (int i = 0; i < 8; i++) begin
      c8_wr_addr = 3'(i); c8_wr_data = 8'(8'h10 + i);
      step();
    end
    c8_wr_en = 0; c8_rd_addr_a = 7; c8_rd_addr_b = 4;
    step();
    check("c8 e7 before clear", c8_rd_data_a, 16'h0017);
    check("c8 e4 before clear", c8_rd_data_b, 16'h0014);
    c8_clear = 1; c8_wr_en = 1; c8_wr_addr = 5; c8_wr_data = 8'hFF; c8_rd_addr_a = 5; c8_rd_addr_b = 5;
    step();
    check("c8 clear a", c8_rd_data_a, 16'h0000);
    check("c8 clear b", c8_rd_data_b, 16'h0000);
    c8_clear = 0; c8_wr_en = 0;
    for (int i = 0; i < 8; i++) begin
      c8_rd_addr_a = 3'(i); c8_rd_addr_b = 3'(7 - i);
      step();
      check($sformatf("c8 cleared e%0d a", i), c8_rd_data_a, 16'h0000);
      check($sformatf("c8 cleared e%0d b", 7 - i), c8_rd_data_b, 16'h0000);
    end

    // Out of range on a depth-6 bank
    d6_wr_en = 1; d6_wr_addr = 0; d6_wr_data = 8'h3C;
    step();
    d6_wr_addr = 6; d6_wr_data = 8'h77; d6_rd_addr_a = 7; d6_rd_addr_b = 0;
    step();
    check("d6 oor read a", d6_rd_data_a, 16'h0000);
    check("d6 e0 b", d6_rd_data_b, 16'h003C);
    d6_wr_addr = 7; d6_wr_data = 8'h99; d6_rd_addr_a = 6; d6_rd_addr_b = 7;
    step();
    check("d6 oor bypass a", d6_rd_data_a, 16'h0000);
    check("d6 oor bypass b", d6_rd_data_b, 16'h0000);
    d6_wr_en = 0;
    for (int i = 0; i < 6; i++) begin
      d6_rd_addr_a = 3'(i); d6_rd_addr_b = 3'(i);
      step();
      check($sformatf("d6 e%0d a", i), d6_rd_data_a, (i == 0) ? 16'h003C : 16'h005A);
      check($sformatf("d6 e%0d b", i), d6_rd_data_b, (i == 0) ? 16'h003C : 16'h005A);
    end
    d6_clear = 1; d6_rd_addr_a = 7;
    step();
    check("d6 clear a", d6_rd_data_a, 16'h005A);
    check("d6 clear b", d6_rd_data_b, 16'h005A);
    d6_clear = 0; d6_rd_addr_a = 0;
    step();
    check("d6 e0 after clear", d6_rd_data_a, 16'h005A);

    // 16-bit words stored bit-exact
    w16_wr_en = 1; w16_wr_addr = 0; w16_wr_data = 16'hBEEF; w16_rd_addr_a = 0; w16_rd_addr_b = 0;
    step();
    check("w16 bypass a", w16_rd_data_a, 16'hBEEF);
    check("w16 bypass b", w16_rd_data_b, 16'hBEEF);
    w16_wr_addr = 7; w16_wr_data = 16'h8001;
    step();
    w16_wr_en = 0; w16_rd_addr_b = 7;
    step();
    check("w16 e0 a", w16_rd_data_a, 16'hBEEF);
    check("w16 e7 b", w16_rd_data_b, 16'h8001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
